// File: rtl/batch_scheduler_pkg.sv
// Shared types and ring-address helper for the backward-recursion
// batch scheduler.
package batch_scheduler_pkg;

    localparam int M = 1;

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        RUN
    } sched_state_t;

    typedef struct packed {
        logic [M-1:0] data;
        logic         warm;
        logic         last;
    } bsample_t;

    // |delta| < size, so a single correction keeps the result in range
    function automatic int ring_add(int addr, int delta, int size);
        int s;
        s = addr + delta;
        if (s >= size) s = s - size;
        else if (s < 0) s = s + size;
        return s;
    endfunction

endpackage

// File: rtl/batch_scheduler_fifo.sv
// Two-entry output FIFO carrying replayed samples and their tags
// to the backward datapath.
module skid_fifo2
    import batch_scheduler_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push_i,
    input  bsample_t   data_i,
    input  logic       pop_i,
    output logic       valid_o,
    output bsample_t   data_o,
    output logic [1:0] count_o
);

    bsample_t   mem_q [2];
    logic       wp_q;
    logic       rp_q;
    logic [1:0] cnt_q;
    logic       pop;

    assign valid_o = cnt_q != 2'd0;
    assign pop     = pop_i & valid_o;
    assign data_o  = mem_q[rp_q];
    assign count_o = cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wp_q     <= 1'b0;
            rp_q     <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wp_q] <= data_i;
                wp_q        <= ~wp_q;
            end
            if (pop) rp_q <= ~rp_q;
            cnt_q <= cnt_q + {1'b0, push_i} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/batch_scheduler.sv
// Ring-buffer writer plus newest-to-oldest replay sequencer feeding
// the backward recursion (prime over lookahead, then the segment).
module batch_scheduler
    import batch_scheduler_pkg::*;
#(
    parameter int DEPTH     = 240,
    parameter int LOOKAHEAD = 20,
    parameter int NSEG      = 4,
    parameter int AW        = $clog2(NSEG * DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [M-1:0]  in,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [M-1:0]  wr_data,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [M-1:0]  rd_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [M-1:0]  out_data,
    output logic          out_warm,
    output logic          out_last,
    output logic          overrun
);

    localparam int RING = NSEG * DEPTH;
    localparam int SW   = $clog2(NSEG);
    localparam int PW   = $clog2(NSEG + 1);
    localparam int CW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    sched_state_t  state_q, state_d;
    logic [AW-1:0] wptr_q, raddr_q, raddr_d;
    logic [CW-1:0] woff_q, cnt_q, cnt_d;
    logic [SW-1:0] wseg_q, rseg_q, kseg_q, kseg_d;
    logic [PW-1:0] pend_q, pend_d;
    logic          lap_q, ovr_q, ovr_d;
    logic          fly_q, fly_warm_q, fly_last_q;
    logic          warm_rd, last_rd, can_rd;
    logic          elig, deq, pop;
    logic [1:0]    fcnt;
    bsample_t      head;

    assign wr_en   = in_valid;
    assign wr_addr = wptr_q;
    assign wr_data = in;
    assign rd_addr = raddr_q;
    assign overrun = ovr_q;

    assign pop    = out_valid & out_ready;
    assign can_rd = (int'(fcnt) - int'(pop) + int'(fly_q)) < 2;
    assign elig   = in_valid && woff_q == CW'(LOOKAHEAD - 1)
                    && (wseg_q != '0 || lap_q);
    assign deq    = pend_q != '0 && (state_q == IDLE || last_rd);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (deq) state_d = PRIME;
            PRIME:   if (rd_en && cnt_q == '0) state_d = RUN;
            RUN:     if (last_rd) state_d = deq ? PRIME : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_en   = 1'b0;
        warm_rd = 1'b0;
        last_rd = 1'b0;
        unique case (1'b1)
            (state_q == PRIME): begin
                rd_en   = can_rd;
                warm_rd = 1'b1;
            end
            (state_q == RUN): begin
                rd_en   = can_rd;
                last_rd = can_rd && cnt_q == '0;
            end
            default: ;
        endcase
    end

    // Reader address walk; a dequeue restarts from the next prime block
    always_comb begin
        kseg_d  = kseg_q;
        cnt_d   = cnt_q;
        raddr_d = raddr_q;
        if (deq) begin
            kseg_d  = rseg_q;
            cnt_d   = CW'(LOOKAHEAD - 1);
            raddr_d = AW'(ring_add(int'(rseg_q) * DEPTH,
                                   DEPTH + LOOKAHEAD - 1, RING));
        end else if (rd_en) begin
            if (state_q == PRIME && cnt_q == '0) begin
                cnt_d   = CW'(DEPTH - 1);
                raddr_d = AW'(int'(kseg_q) * DEPTH + DEPTH - 1);
            end else begin
                cnt_d   = cnt_q - 1'b1;
                raddr_d = AW'(ring_add(int'(raddr_q), -1, RING));
            end
        end
    end

    always_comb begin
        pend_d = pend_q;
        if (elig && !deq && pend_q != PW'(NSEG)) pend_d = pend_q + 1'b1;
        else if (deq && !elig) pend_d = pend_q - 1'b1;
        ovr_d = ovr_q | (in_valid && woff_q == '0
                && int'(pend_q) + int'(state_q != IDLE) >= NSEG - 1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q     <= '0;
            woff_q     <= '0;
            wseg_q     <= '0;
            lap_q      <= 1'b0;
            pend_q     <= '0;
            rseg_q     <= '0;
            kseg_q     <= '0;
            cnt_q      <= '0;
            raddr_q    <= '0;
            ovr_q      <= 1'b0;
            fly_q      <= 1'b0;
            fly_warm_q <= 1'b0;
            fly_last_q <= 1'b0;
        end else begin
            if (in_valid) begin
                wptr_q <= AW'(ring_add(int'(wptr_q), 1, RING));
                if (woff_q == CW'(DEPTH - 1)) begin
                    woff_q <= '0;
                    wseg_q <= (wseg_q == SW'(NSEG - 1)) ? '0 : wseg_q + 1'b1;
                end else begin
                    woff_q <= woff_q + 1'b1;
                end
                if (wseg_q != '0) lap_q <= 1'b1;
            end
            if (deq) rseg_q <= (rseg_q == SW'(NSEG - 1)) ? '0 : rseg_q + 1'b1;
            pend_q     <= pend_d;
            kseg_q     <= kseg_d;
            cnt_q      <= cnt_d;
            raddr_q    <= raddr_d;
            ovr_q      <= ovr_d;
            fly_q      <= rd_en;
            fly_warm_q <= warm_rd;
            fly_last_q <= last_rd;
        end
    end

    skid_fifo2 u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .push_i  (fly_q),
        .data_i  ('{data: rd_data, warm: fly_warm_q, last: fly_last_q}),
        .pop_i   (pop),
        .valid_o (out_valid),
        .data_o  (head),
        .count_o (fcnt)
    );

    assign out_data = head.data;
    assign out_warm = head.warm;
    assign out_last = head.last;

endmodule
